// File: rtl/key_event_pkg.sv
// key_event_pkg: shared types and default timing constants for the key
// gesture classifier.
//   state_t            - gesture state encoding used by key_event
//   *_CYCLES_DEF       - default timing parameters (100 kHz scan clock)
//   max3()             - helper used to size the shared counter
package key_event_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        WAIT2,
        PRESS2,
        LONG
    } state_t;

    localparam int unsigned LONG_CYCLES_DEF   = 100000;
    localparam int unsigned DBL_CYCLES_DEF    = 30000;
    localparam int unsigned REPEAT_CYCLES_DEF = 20000;

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/key_event_if.sv
// key_event_if: key level in, gesture events out.
//   key_in      - debounced key level, 1 = pressed
//   press       - pulse on every accepted press
//   key_release - pulse on release of a tracked press
//   click       - pulse on a single click
//   dbl_click   - pulse on the second press of a double click
//   long_press  - pulse when a first press is held long enough
//   key_repeat  - periodic pulse while a long press is held
//   holding     - level, high while a press is being tracked
// master: key source / event consumer side; slave: the classifier.
interface key_event_if;

    logic key_in;
    logic press;
    logic key_release;
    logic click;
    logic dbl_click;
    logic long_press;
    logic key_repeat;
    logic holding;

    modport master (
        output key_in,
        input  press, key_release, click, dbl_click,
        input  long_press, key_repeat, holding
    );

    modport slave (
        input  key_in,
        output press, key_release, click, dbl_click,
        output long_press, key_repeat, holding
    );

endinterface

// File: rtl/key_edge.sv
// key_edge: registers the key level once and flags rising/falling edges.
//   clk_100kHz - scan clock
//   rst        - synchronous active-high reset
//   i_key      - debounced key level
//   o_rise     - key_in high while the registered copy is low
//   o_fall     - key_in low while the registered copy is high
module key_edge (
    input  logic clk_100kHz,
    input  logic rst,
    input  logic i_key,
    output logic o_rise,
    output logic o_fall
);

    logic r_key_q;

    // Reset value 1: a key already held through reset yields no rise,
    // so a fresh press is needed before anything is reported.
    always_ff @(posedge clk_100kHz) begin
        if (rst) r_key_q <= 1'b1;
        else     r_key_q <= i_key;
    end

    assign o_rise = i_key & ~r_key_q;
    assign o_fall = ~i_key & r_key_q;

endmodule

// File: rtl/key_event.sv
// key_event: classifies a debounced key level into press, release, click,
// double click, long press and auto-repeat pulses plus a holding level.
//   clk_100kHz - scan clock, all logic on its rising edge
//   rst        - synchronous active-high reset
//   bus        - key_event_if.slave: key_in in, registered events out
// Parameters: LONG_CYCLES, DBL_CYCLES, REPEAT_CYCLES (each >= 2).
module key_event
    import key_event_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
    parameter int unsigned DBL_CYCLES    = DBL_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
    input  logic        clk_100kHz,
    input  logic        rst,
    key_event_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(max3(LONG_CYCLES, DBL_CYCLES, REPEAT_CYCLES));

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] DBL_LAST    = CNT_W'(DBL_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic w_rise;
    logic w_fall;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    logic r_press, r_release, r_click, r_dbl, r_long, r_repeat, r_holding;
    logic w_press, w_release, w_click, w_dbl, w_long, w_repeat, w_holding;

    key_edge u_edge (
        .clk_100kHz (clk_100kHz),
        .rst        (rst),
        .i_key      (bus.key_in),
        .o_rise     (w_rise),
        .o_fall     (w_fall)
    );

    // Next state, next counter and next pulse values. Edge events take
    // priority over counter thresholds, so a release on the long
    // threshold stays a short press and a press on the double-click
    // timeout stays a double click.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_press     = 1'b0;
        w_release   = 1'b0;
        w_click     = 1'b0;
        w_dbl       = 1'b0;
        w_long      = 1'b0;
        w_repeat    = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_rise) begin
                    w_state_nxt = PRESS1;
                    w_press     = 1'b1;
                end
            end

            PRESS1: begin
                if (w_fall) begin
                    w_state_nxt = WAIT2;
                    w_cnt_nxt   = '0;
                    w_release   = 1'b1;
                end else if (r_cnt == LONG_LAST) begin
                    w_state_nxt = LONG;
                    w_cnt_nxt   = '0;
                    w_long      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            WAIT2: begin
                if (w_rise) begin
                    w_state_nxt = PRESS2;
                    w_cnt_nxt   = '0;
                    w_press     = 1'b1;
                    w_dbl       = 1'b1;
                end else if (r_cnt == DBL_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_click     = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            PRESS2: begin
                w_cnt_nxt = '0;
                if (w_fall) begin
                    w_state_nxt = IDLE;
                    w_release   = 1'b1;
                end
            end

            LONG: begin
                if (w_fall) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                    w_release   = 1'b1;
                end else if (r_cnt == REPEAT_LAST) begin
                    w_cnt_nxt = '0;
                    w_repeat  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        // holding follows the registered state, so it rises with press
        // and drops with release in the same cycle as those pulses.
        w_holding = (w_state_nxt == PRESS1) || (w_state_nxt == PRESS2) ||
                    (w_state_nxt == LONG);
    end

    always_ff @(posedge clk_100kHz) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_click   <= 1'b0;
            r_dbl     <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
            r_holding <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_press   <= w_press;
            r_release <= w_release;
            r_click   <= w_click;
            r_dbl     <= w_dbl;
            r_long    <= w_long;
            r_repeat  <= w_repeat;
            r_holding <= w_holding;
        end
    end

    assign bus.press       = r_press;
    assign bus.key_release = r_release;
    assign bus.click       = r_click;
    assign bus.dbl_click   = r_dbl;
    assign bus.long_press  = r_long;
    assign bus.key_repeat  = r_repeat;
    assign bus.holding     = r_holding;

endmodule
